// File: rtl/dac_spi_pkg.sv
// Shared encodings for the DAC SPI responder: command codes, broadcast
// address, frame length and the frame-control state type.
package dac_spi_pkg;

  localparam int FRAME_BITS = 24;

  localparam logic [3:0] CMD_WR    = 4'h0;
  localparam logic [3:0] CMD_UPD   = 4'h1;
  localparam logic [3:0] CMD_WRUPD = 4'h3;
  localparam logic [3:0] CMD_PD    = 4'h4;
  localparam logic [3:0] CMD_NOP   = 4'hF;

  localparam logic [3:0] ADDR_ALL  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer for one SPI pin plus a third flop that turns the
// synchronized level into single-cycle rise/fall pulses.
module spi_in_sync #(
  parameter logic INIT = 1'b0
) (
  input  logic CLKB,
  input  logic RESET,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [2:0] stg_r;

  // stg_r[1] is the synchronized level, stg_r[2] its one-cycle-old copy
  always_ff @(posedge CLKB or negedge RESET) begin
    if (!RESET) begin
      stg_r <= {3{INIT}};
    end else begin
      stg_r <= {stg_r[1:0], din};
    end
  end

  assign lvl  = stg_r[1];
  assign rise = stg_r[1] & ~stg_r[2];
  assign fall = ~stg_r[1] & stg_r[2];

endmodule

// File: rtl/dac_spi_resp.sv
// Emulated multi-channel SPI DAC: receives 24-bit frames, applies the DAC
// commands and echoes the previously accepted frame on MISO.
module dac_spi_resp #(
  parameter int NCH        = 8,
  parameter int FRAME_BITS = dac_spi_pkg::FRAME_BITS
) (
  input  logic                CLKB,
  input  logic                RESET,
  input  logic                spi_sync,
  input  logic                spi_sclk,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                frame_valid,
  output logic                frame_err,
  output logic [3:0]          frame_cmd,
  output logic [3:0]          frame_addr,
  output logic [15:0]         frame_data,
  output logic [NCH*16-1:0]   dac_code,
  output logic [NCH-1:0]      pd_mask
);

  import dac_spi_pkg::*;

  logic sync_lvl_s, sync_rise_s, sync_fall_s;
  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic mosi_lvl_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  spi_in_sync #(.INIT(1'b1)) u_sync_sync (
    .CLKB(CLKB), .RESET(RESET), .din(spi_sync),
    .lvl(sync_lvl_s), .rise(sync_rise_s), .fall(sync_fall_s)
  );

  spi_in_sync #(.INIT(1'b0)) u_sclk_sync (
    .CLKB(CLKB), .RESET(RESET), .din(spi_sclk),
    .lvl(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_in_sync #(.INIT(1'b0)) u_mosi_sync (
    .CLKB(CLKB), .RESET(RESET), .din(spi_mosi),
    .lvl(mosi_lvl_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  assign unused_s = ^{sclk_lvl_s, mosi_rise_s, mosi_fall_s};

  logic [1:0]            live_r;
  logic                  armed_r;
  state_e                state_r, state_s;
  logic [4:0]            bit_cnt_r;
  logic [FRAME_BITS-1:0] shift_r, echo_r, miso_sh_r, load_s;
  logic                  miso_r;
  logic                  start_s, in_frame_s, commit_s, good_s;
  logic [3:0]            cmd_s, addr_s;
  logic [15:0]           data_s;
  logic [15:0]           in_reg_r [NCH];
  logic [15:0]           dac_r    [NCH];
  logic [NCH-1:0]        pd_r;
  logic                  frame_valid_r, frame_err_r;
  logic [3:0]            frame_cmd_r, frame_addr_r;
  logic [15:0]           frame_data_r;

  // Sync stages reset high, so a line still held low after reset would look
  // like a fall; frames only start once sync has really been seen high.
  always_ff @(posedge CLKB or negedge RESET) begin
    if (!RESET) begin
      live_r  <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      live_r <= {live_r[0], 1'b1};
      if (live_r[1] && sync_lvl_s) begin
        armed_r <= 1'b1;
      end
    end
  end

  assign start_s    = sync_fall_s & armed_r;
  assign in_frame_s = (state_r == ST_SHIFT) & ~sync_lvl_s;
  assign commit_s   = (state_r == ST_COMMIT);
  assign good_s     = commit_s & (bit_cnt_r == 5'(FRAME_BITS));
  assign cmd_s      = shift_r[FRAME_BITS-1 -: 4];
  assign addr_s     = shift_r[FRAME_BITS-5 -: 4];
  assign data_s     = shift_r[15:0];
  // A frame committed in the same cycle a new one starts is echoed at once.
  assign load_s     = good_s ? shift_r : echo_r;

  always_ff @(posedge CLKB or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_SHIFT;
        else         state_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (sync_rise_s) state_s = ST_COMMIT;
        else             state_s = ST_SHIFT;
      end
      ST_COMMIT: begin
        if (start_s) state_s = ST_SHIFT;
        else         state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLKB or negedge RESET) begin
    if (!RESET) begin
      bit_cnt_r <= 5'd0;
      shift_r   <= '0;
      miso_sh_r <= '0;
      miso_r    <= 1'b0;
    end else if (start_s) begin
      bit_cnt_r <= 5'd0;
      shift_r   <= '0;
      miso_sh_r <= load_s;
      miso_r    <= load_s[FRAME_BITS-1];
    end else if (in_frame_s) begin
      if (sclk_rise_s) begin
        shift_r   <= {shift_r[FRAME_BITS-2:0], mosi_lvl_s};
        bit_cnt_r <= (bit_cnt_r == 5'd31) ? bit_cnt_r : bit_cnt_r + 5'd1;
      end
      if (sclk_fall_s) begin
        miso_sh_r <= {miso_sh_r[FRAME_BITS-2:0], 1'b0};
        miso_r    <= miso_sh_r[FRAME_BITS-2];
      end
    end else begin
      miso_r <= 1'b0;
    end
  end

  always_ff @(posedge CLKB or negedge RESET) begin
    if (!RESET) begin
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      frame_cmd_r   <= 4'h0;
      frame_addr_r  <= 4'h0;
      frame_data_r  <= 16'h0000;
      echo_r        <= '0;
      pd_r          <= '0;
      for (int i = 0; i < NCH; i++) begin
        in_reg_r[i] <= 16'h0000;
        dac_r[i]    <= 16'h0000;
      end
    end else begin
      frame_valid_r <= good_s;
      frame_err_r   <= commit_s & ~good_s;
      if (good_s) begin
        frame_cmd_r  <= cmd_s;
        frame_addr_r <= addr_s;
        frame_data_r <= data_s;
        echo_r       <= shift_r;
      end
      for (int i = 0; i < NCH; i++) begin
        if (good_s && ((addr_s == ADDR_ALL) || (addr_s == 4'(i)))) begin
          case (cmd_s)
            CMD_WR: in_reg_r[i] <= data_s;
            CMD_UPD: begin
              dac_r[i] <= in_reg_r[i];
              pd_r[i]  <= 1'b0;
            end
            CMD_WRUPD: begin
              in_reg_r[i] <= data_s;
              dac_r[i]    <= data_s;
              pd_r[i]     <= 1'b0;
            end
            CMD_PD:  pd_r[i] <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_dac
    assign dac_code[16*g +: 16] = dac_r[g];
  end

  assign spi_miso    = miso_r;
  assign frame_valid = frame_valid_r;
  assign frame_err   = frame_err_r;
  assign frame_cmd   = frame_cmd_r;
  assign frame_addr  = frame_addr_r;
  assign frame_data  = frame_data_r;
  assign pd_mask     = pd_r;

endmodule

// File: tb/tb_dac_spi_resp.sv
// Randomized bench for dac_spi_resp: an SPI master task drives frames and a
// frame-level model of the DAC registers predicts every observable output.
module tb_dac_spi_resp;

  localparam int  NCH = 8;
  localparam time SH  = 45;

  logic              CLKB = 1'b0;
  logic              RESET = 1'b0;
  logic              spi_sync = 1'b1;
  logic              spi_sclk = 1'b0;
  logic              spi_mosi = 1'b0;
  logic              spi_miso, frame_valid, frame_err;
  logic [3:0]        frame_cmd, frame_addr;
  logic [15:0]       frame_data;
  logic [NCH*16-1:0] dac_code;
  logic [NCH-1:0]    pd_mask;

  dac_spi_resp #(.NCH(NCH), .FRAME_BITS(24)) dut (
    .CLKB(CLKB), .RESET(RESET), .spi_sync(spi_sync), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .frame_valid(frame_valid),
    .frame_err(frame_err), .frame_cmd(frame_cmd), .frame_addr(frame_addr),
    .frame_data(frame_data), .dac_code(dac_code), .pd_mask(pd_mask)
  );

  always #5 CLKB = ~CLKB;

  // reference model state
  logic [15:0]    in_m  [NCH];
  logic [15:0]    dac_m [NCH];
  logic [NCH-1:0] pd_m;
  logic [23:0]    echo_m;
  logic [3:0]     cmd_m, addr_m;
  logic [15:0]    data_m;
  int             exp_vld = 0, exp_err = 0;

  int  n_vec = 0, n_err = 0;
  int  vld_cnt = 0, err_cnt = 0, last_lat = -1;
  time t_rise = 0;

  // pulse monitor: counts high cycles and their distance from the sync rise
  always @(negedge CLKB) begin
    if (frame_valid) begin
      vld_cnt  <= vld_cnt + 1;
      last_lat <= int'(($time - t_rise) / 10);
    end
    if (frame_err) begin
      err_cnt  <= err_cnt + 1;
      last_lat <= int'(($time - t_rise) / 10);
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      in_m[i]  = 16'h0000;
      dac_m[i] = 16'h0000;
    end
    pd_m = '0; echo_m = 24'h0; cmd_m = 4'h0; addr_m = 4'h0; data_m = 16'h0;
  endtask

  task automatic model_frame(input logic [31:0] bits, input int n);
    if (n == 24) begin
      exp_vld++;
      echo_m = bits[23:0];
      cmd_m  = bits[23:20];
      addr_m = bits[19:16];
      data_m = bits[15:0];
      for (int ch = 0; ch < NCH; ch++) begin
        if (addr_m == 4'hF || int'(addr_m) == ch) begin
          case (cmd_m)
            4'h0: in_m[ch] = data_m;
            4'h1: begin dac_m[ch] = in_m[ch]; pd_m[ch] = 1'b0; end
            4'h3: begin in_m[ch] = data_m; dac_m[ch] = data_m; pd_m[ch] = 1'b0; end
            4'h4: pd_m[ch] = 1'b1;
            default: ;
          endcase
        end
      end
    end else begin
      exp_err++;
    end
  endtask

  function automatic logic [NCH*16-1:0] dac_flat();
    logic [NCH*16-1:0] v;
    for (int i = 0; i < NCH; i++) v[16*i +: 16] = dac_m[i];
    return v;
  endfunction

  // clocks n bits, MSB first, sampling MISO just before every sclk rise
  task automatic clock_bits(input logic [31:0] bits, input int n, output logic [31:0] cap);
    cap = 32'h0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      #SH;
      cap = {cap[30:0], spi_miso};
      spi_sclk = 1'b1;
      #SH;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_dac"},  dac_code, dac_flat());
    check_eq({tag, "_pd"},   pd_mask, pd_m);
    check_eq({tag, "_fld"},  {frame_cmd, frame_addr, frame_data}, {cmd_m, addr_m, data_m});
    check_eq({tag, "_nvld"}, vld_cnt, exp_vld);
    check_eq({tag, "_nerr"}, err_cnt, exp_err);
    check_eq({tag, "_miso_idle"}, spi_miso, 1'b0);
  endtask

  task automatic do_frame(input string tag, input logic [31:0] bits, input int n, input bit b2b);
    logic [31:0] cap;
    logic [23:0] echo_before;
    int k;
    echo_before = echo_m;
    if (spi_sync) begin
      @(negedge CLKB);
      spi_sync = 1'b0;
    end
    clock_bits(bits, n, cap);
    #SH;
    @(negedge CLKB);
    spi_sync = 1'b1;
    t_rise = $time;
    if (b2b) begin
      @(negedge CLKB);
      spi_sync = 1'b0;
    end else begin
      repeat (8) @(negedge CLKB);
    end
    model_frame(bits, n);
    k = (n > 24) ? 24 : n;
    if (k > 0) begin
      check_eq({tag, "_echo"}, (cap >> (n - k)) & ((32'd1 << k) - 32'd1),
               {8'h00, echo_before} >> (24 - k));
    end
    if (!b2b) begin
      check_outputs(tag);
      check_eq({tag, "_lat"}, last_lat, 4);
    end
  endtask

  logic [3:0]  cmd_tab [7];
  logic [31:0] cap_r, bits_r;
  int          len_r, sel_r;
  bit          b2b_r;

  initial begin
    cmd_tab[0] = 4'h0; cmd_tab[1] = 4'h1; cmd_tab[2] = 4'h3; cmd_tab[3] = 4'h4;
    cmd_tab[4] = 4'hF; cmd_tab[5] = 4'h2; cmd_tab[6] = 4'h7;
    model_reset();
    #2;
    check_outputs("reset");
    repeat (3) @(negedge CLKB);
    RESET = 1'b1;
    repeat (6) @(negedge CLKB);

    do_frame("wrupd2", {8'h0, 4'h3, 4'h2, 16'h8000}, 24, 1'b0);
    check_eq("wrupd2_ch2", dac_code[47:32], 16'h8000);

    do_frame("wr1", {8'h0, 4'h0, 4'h1, 16'h1234}, 24, 1'b0);
    check_eq("wr1_ch1", dac_code[31:16], 16'h0000);
    do_frame("upd1", {8'h0, 4'h1, 4'h1, 16'h0000}, 24, 1'b0);
    check_eq("upd1_ch1", dac_code[31:16], 16'h1234);

    do_frame("short23", 32'h00_3_1_5555, 23, 1'b0);
    do_frame("long25",  32'h01_3_1_AAAA, 25, 1'b0);

    do_frame("bcast", 32'h00_3F_ABCD, 24, 1'b0);
    check_eq("bcast_all", dac_code, {NCH{16'hABCD}});
    do_frame("after_bcast", 32'h00_F0_0000, 24, 1'b0);

    do_frame("pd0", 32'h00_40_0000, 24, 1'b0);
    check_eq("pd0_set", pd_mask[0], 1'b1);
    do_frame("wrupd0", 32'h00_30_1111, 24, 1'b0);
    check_eq("pd0_clr", pd_mask[0], 1'b0);

    do_frame("oob_addr", 32'h00_39_7777, 24, 1'b0);

    // back-to-back: next frame's sync fall lands in the commit cycle
    do_frame("b2b_a", 32'h00_35_0F0F, 24, 1'b1);
    do_frame("b2b_b", 32'h00_36_F0F0, 24, 1'b0);

    // reset in the middle of a frame, remainder of that frame ignored
    bits_r = 32'h00_37_5A5A;
    @(negedge CLKB);
    spi_sync = 1'b0;
    clock_bits(bits_r >> 12, 12, cap_r);
    @(negedge CLKB);
    RESET = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_dac", dac_code, '0);
    check_eq("midrst_misc", {spi_miso, frame_valid, frame_err, pd_mask}, '0);
    repeat (3) @(negedge CLKB);
    RESET = 1'b1;
    clock_bits(bits_r, 12, cap_r);
    #SH;
    @(negedge CLKB);
    spi_sync = 1'b1;
    repeat (8) @(negedge CLKB);
    check_outputs("midrst_after");
    do_frame("post_rst", 32'h00_32_2222, 24, 1'b0);

    for (int it = 0; it < 40; it++) begin
      bits_r = $urandom;
      bits_r[23:20] = cmd_tab[$urandom_range(0, 6)];
      sel_r = $urandom_range(0, 9);
      if (sel_r <= 6)      len_r = 24;
      else if (sel_r == 7) len_r = 23;
      else if (sel_r == 8) len_r = 25;
      else                 len_r = $urandom_range(0, 26);
      b2b_r = ($urandom_range(0, 3) == 0) && (it != 39);
      do_frame("rnd", bits_r, len_r, b2b_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
